// File: rtl/prbs_ber_meter_if.sv
// rtl/prbs_ber_meter_if.sv - soft-symbol input stream into the PRBS BER meter
interface prbs_ber_meter_if #(
  parameter int SOFT_W = 5
) ();
  logic              ival;
  logic [SOFT_W-1:0] idat;

  modport master (output ival, idat);
  modport slave  (input  ival, idat);
endinterface

// File: rtl/prbs_ber_meter.sv
// rtl/prbs_ber_meter.sv - self-synchronising PRBS checker with lock tracking and BER counters
// Optional macro PRBS_ERR_INJECT_EN adds the inj port for self-test error injection.
module prbs_ber_meter #(
  parameter int SOFT_W   = 5,
  parameter int CNT_W    = 24,
  parameter int TOT_W    = 32,
  parameter int LOCK_LEN = 32,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst,
  prbs_ber_meter_if.slave  s_in,
  input  logic [1:0]       poly_sel,
  input  logic [CNT_W-1:0] win_len,
  input  logic             clr,
  output logic             locked,
  output logic             bit_err,
  output logic             oval,
  output logic [CNT_W-1:0] n_bits,
  output logic [CNT_W-1:0] n_err,
  output logic [TOT_W-1:0] err_total,
  output logic [7:0]       n_loss
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic             inj
`endif
);
  localparam int MW  = $clog2(LOCK_LEN + 1);
  localparam int LBW = $clog2(LOSS_WIN + 1);
  localparam int LEW = $clog2(LOSS_THR + 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state, state_nx, state_eff;
  logic [30:0]      sreg, sreg_nx;
  logic [1:0]       poly_q;
  logic [4:0]       fill_cnt, fill_nx, order;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [LBW-1:0]   lb_cnt, lb_cnt_nx;
  logic [LEW-1:0]   lb_err, lb_err_nx;
  logic [CNT_W-1:0] win_cnt, win_cnt_nx, win_err, win_err_nx;
  logic [CNT_W-1:0] win_len_q, win_len_q_nx, win_len_eff;
  logic [CNT_W-1:0] n_bits_nx, n_err_nx;
  logic [TOT_W-1:0] err_total_nx;
  logic [7:0]       n_loss_nx;
  logic             bit_err_nx, oval_nx;
  logic             rx, pred, mismatch, poly_chg;
  logic             idat_unused;

`ifdef PRBS_ERR_INJECT_EN
  assign rx = ~s_in.idat[SOFT_W-1] ^ inj;
`else
  assign rx = ~s_in.idat[SOFT_W-1];
`endif
  assign idat_unused = ^s_in.idat[SOFT_W-2:0];
  assign mismatch    = pred != rx;
  assign poly_chg    = poly_sel != poly_q;
  assign locked      = state == LOCK;

  always_comb begin
    order = 5'd7;
    pred  = sreg[6] ^ sreg[5];
    case (poly_sel)
      2'd0: begin order = 5'd7;  pred = sreg[6]  ^ sreg[5];  end
      2'd1: begin order = 5'd15; pred = sreg[14] ^ sreg[13]; end
      2'd2: begin order = 5'd23; pred = sreg[22] ^ sreg[17]; end
      default: begin order = 5'd31; pred = sreg[30] ^ sreg[27]; end
    endcase
  end

  // A polynomial change acts as an immediate return to HUNT with cleared counters,
  // and the bit arriving in the same cycle is already checked against the new polynomial.
  always_comb begin
    state_eff    = poly_chg ? HUNT : state;
    state_nx     = state_eff;
    sreg_nx      = sreg;
    fill_nx      = poly_chg ? '0 : fill_cnt;
    match_nx     = poly_chg ? '0 : match_cnt;
    lb_cnt_nx    = poly_chg ? '0 : lb_cnt;
    lb_err_nx    = poly_chg ? '0 : lb_err;
    win_cnt_nx   = poly_chg ? '0 : win_cnt;
    win_err_nx   = poly_chg ? '0 : win_err;
    win_len_q_nx = win_len_q;
    n_bits_nx    = n_bits;
    n_err_nx     = n_err;
    err_total_nx = err_total;
    n_loss_nx    = n_loss;
    bit_err_nx   = 1'b0;
    oval_nx      = 1'b0;
    win_len_eff  = (win_cnt_nx == '0) ? win_len : win_len_q;

    if (s_in.ival) begin
      if (state_eff == HUNT) begin
        sreg_nx = {sreg[29:0], rx};
        if (fill_nx != order) begin
          fill_nx = fill_nx + 5'd1;
        end else if (mismatch) begin
          match_nx = '0;
        end else if (match_nx == MW'(LOCK_LEN - 1)) begin
          match_nx = '0;
          state_nx = LOCK;
        end else begin
          match_nx = match_nx + MW'(1);
        end
      end else begin
        sreg_nx    = {sreg[29:0], pred};
        bit_err_nx = mismatch;
        if (mismatch && err_total != '1)
          err_total_nx = err_total + TOT_W'(1);
        if (mismatch && lb_err_nx == LEW'(LOSS_THR - 1)) begin
          state_nx   = HUNT;
          fill_nx    = '0;
          match_nx   = '0;
          lb_cnt_nx  = '0;
          lb_err_nx  = '0;
          win_cnt_nx = '0;
          win_err_nx = '0;
          if (n_loss != 8'hFF)
            n_loss_nx = n_loss + 8'd1;
        end else begin
          if (lb_cnt_nx == LBW'(LOSS_WIN - 1)) begin
            lb_cnt_nx = '0;
            lb_err_nx = '0;
          end else begin
            lb_cnt_nx = lb_cnt_nx + LBW'(1);
            lb_err_nx = lb_err_nx + LEW'(mismatch);
          end
          if (win_len_eff != '0) begin
            if (win_cnt_nx == '0)
              win_len_q_nx = win_len;
            if (win_cnt_nx + CNT_W'(1) == win_len_eff) begin
              n_bits_nx  = win_cnt_nx + CNT_W'(1);
              n_err_nx   = win_err_nx + CNT_W'(mismatch);
              oval_nx    = 1'b1;
              win_cnt_nx = '0;
              win_err_nx = '0;
            end else begin
              win_cnt_nx = win_cnt_nx + CNT_W'(1);
              win_err_nx = win_err_nx + CNT_W'(mismatch);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= HUNT;
      sreg      <= '0;
      poly_q    <= poly_sel;
      fill_cnt  <= '0;
      match_cnt <= '0;
      lb_cnt    <= '0;
      lb_err    <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      win_len_q <= '0;
      n_bits    <= '0;
      n_err     <= '0;
      err_total <= '0;
      n_loss    <= '0;
      bit_err   <= 1'b0;
      oval      <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      poly_q    <= poly_sel;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      lb_cnt    <= lb_cnt_nx;
      lb_err    <= lb_err_nx;
      win_cnt   <= win_cnt_nx;
      win_err   <= win_err_nx;
      win_len_q <= win_len_q_nx;
      n_bits    <= n_bits_nx;
      n_err     <= n_err_nx;
      err_total <= err_total_nx;
      n_loss    <= n_loss_nx;
      bit_err   <= bit_err_nx;
      oval      <= oval_nx;
    end
  end
endmodule

// File: tb/tb_prbs_ber_meter.sv
// tb/tb_prbs_ber_meter.sv - directed self-checking bench for prbs_ber_meter
module tb_prbs_ber_meter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  poly_sel;
  logic [23:0] win_len;
  logic        clr;
  logic        locked, bit_err, oval;
  logic [23:0] n_bits, n_err;
  logic [31:0] err_total;
  logic [7:0]  n_loss;
`ifdef PRBS_ERR_INJECT_EN
  logic        inj;
`endif

  prbs_ber_meter_if #(.SOFT_W(5)) s_if ();

  prbs_ber_meter dut (
    .clk(clk), .rst(rst), .s_in(s_if), .poly_sel(poly_sel), .win_len(win_len),
    .clr(clr), .locked(locked), .bit_err(bit_err), .oval(oval), .n_bits(n_bits),
    .n_err(n_err), .err_total(err_total), .n_loss(n_loss)
`ifdef PRBS_ERR_INJECT_EN
    , .inj(inj)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] poly;
    int         nbits;
    logic       exp_locked;
  } lock_vec_t;

  lock_vec_t   vecs [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_pulses, oval_cnt, oval_at, bit_idx, vcnt;
  logic [30:0] hist;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference PRBS: b[n] = b[n-a] ^ b[n-b] for the taps of the selected polynomial.
  task automatic gen(output logic b);
    case (poly_sel)
      2'd0: b = hist[6]  ^ hist[5];
      2'd1: b = hist[14] ^ hist[13];
      2'd2: b = hist[22] ^ hist[17];
      default: b = hist[30] ^ hist[27];
    endcase
    hist = {hist[29:0], b};
  endtask

  task automatic sample();
    if (bit_err) err_pulses++;
    if (oval) begin
      oval_cnt++;
      oval_at = bit_idx;
    end
  endtask

  task automatic drive_bit(input logic b);
    s_if.ival = 1'b1;
    if (b) s_if.idat = ($urandom_range(0, 1) == 0) ? 5'd0  : 5'd15;
    else   s_if.idat = ($urandom_range(0, 1) == 0) ? 5'h1F : 5'h10;
    @(posedge clk); #1;
    s_if.ival = 1'b0;
    bit_idx++;
    sample();
  endtask

  task automatic send(input logic flip);
    logic b;
    gen(b);
    drive_bit(b ^ flip);
  endtask

  task automatic idle();
    s_if.ival = 1'b0;
    @(posedge clk); #1;
    sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_if.ival = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hist = '1;
    err_pulses = 0;
    oval_cnt = 0;
    oval_at = -1;
    bit_idx = 0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; poly_sel = 2'd0; win_len = '0;
    s_if.ival = 1'b0; s_if.idat = '0;
`ifdef PRBS_ERR_INJECT_EN
    inj = 1'b0;
`endif
    vecs[0] = '{2'd0, 38, 1'b0};
    vecs[1] = '{2'd0, 39, 1'b1};
    vecs[2] = '{2'd1, 46, 1'b0};
    vecs[3] = '{2'd1, 47, 1'b1};
    vecs[4] = '{2'd2, 54, 1'b0};
    vecs[5] = '{2'd2, 55, 1'b1};
    vecs[6] = '{2'd3, 62, 1'b0};
    vecs[7] = '{2'd3, 63, 1'b1};

    do_reset();
    check("rst_locked", locked, 0);
    check("rst_bit_err", bit_err, 0);
    check("rst_oval", oval, 0);
    check("rst_n_bits", n_bits, 0);
    check("rst_n_err", n_err, 0);
    check("rst_err_total", err_total, 0);
    check("rst_n_loss", n_loss, 0);

    // Lock acquisition boundary: ORDER + LOCK_LEN valid bits on a clean stream
    for (int i = 0; i < 8; i++) begin
      poly_sel = vecs[i].poly;
      do_reset();
      for (int k = 0; k < vecs[i].nbits; k++) send(1'b0);
      check($sformatf("lock_p%0d_n%0d", vecs[i].poly, vecs[i].nbits), locked, vecs[i].exp_locked);
      check($sformatf("clean_bit_err_p%0d", vecs[i].poly), err_pulses, 0);
      check($sformatf("clean_err_total_p%0d", vecs[i].poly), err_total, 0);
    end

    // PRBS23 window of 1000 with errors at 100/500/999
    poly_sel = 2'd2; win_len = 24'd1000;
    do_reset();
    for (int k = 0; k < 55; k++) send(1'b0);
    check("win_locked", locked, 1);
    for (int k = 1; k <= 1000; k++) send(k == 100 || k == 500 || k == 999);
    check("win_oval_cnt", oval_cnt, 1);
    check("win_oval_at", oval_at, 1055);
    check("win_n_bits", n_bits, 1000);
    check("win_n_err", n_err, 3);
    check("win_err_total", err_total, 3);
    check("win_bit_err_pulses", err_pulses, 3);
    check("win_still_locked", locked, 1);
    for (int k = 0; k < 20; k++) send(1'b0);
    check("win_n_bits_hold", n_bits, 1000);

    // PRBS31 loss of lock after 8 errors in one loss block, then relock
    poly_sel = 2'd3; win_len = '0;
    do_reset();
    for (int k = 0; k < 63; k++) send(1'b0);
    check("loss_locked", locked, 1);
    for (int k = 1; k <= 14; k++) send(k[0] == 1'b0);
    check("loss_before_8th", locked, 1);
    send(1'b0);
    send(1'b1);
    check("loss_after_8th", locked, 0);
    check("loss_n_loss", n_loss, 1);
    check("loss_err_total", err_total, 8);
    check("loss_oval_none", oval_cnt, 0);
    for (int k = 0; k < 62; k++) send(1'b0);
    check("relock_62", locked, 0);
    send(1'b0);
    check("relock_63", locked, 1);

    // PRBS15 locked, then switch to PRBS23
    poly_sel = 2'd1;
    do_reset();
    for (int k = 0; k < 47; k++) send(1'b0);
    check("chg_locked15", locked, 1);
    poly_sel = 2'd2;
    hist = '1;
    idle();
    check("chg_hunt", locked, 0);
    check("chg_n_loss", n_loss, 0);
    for (int k = 0; k < 54; k++) send(1'b0);
    check("chg_lock_54", locked, 0);
    send(1'b0);
    check("chg_lock_55", locked, 1);
    check("chg_bit_err", err_pulses, 0);

    // 30% ival duty on PRBS23, a 10-bit window with one error, then clr
    poly_sel = 2'd2; win_len = 24'd10;
    do_reset();
    vcnt = 0;
    for (int c = 0; c < 2000 && vcnt < 55; c++) begin
      if ($urandom_range(0, 99) < 30) begin
        send(1'b0);
        vcnt++;
        if (vcnt == 54) check("rand_lock_54", locked, 0);
        else if (vcnt == 55) check("rand_lock_55", locked, 1);
      end else begin
        idle();
      end
    end
    check("rand_valid_reached", vcnt, 55);
    for (int k = 1; k <= 10; k++) begin
      send(k == 5);
      idle();
    end
    check("rand_oval_cnt", oval_cnt, 1);
    check("rand_n_bits", n_bits, 10);
    check("rand_n_err", n_err, 1);
    check("rand_err_total", err_total, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_locked", locked, 0);
    check("clr_bit_err", bit_err, 0);
    check("clr_oval", oval, 0);
    check("clr_n_bits", n_bits, 0);
    check("clr_n_err", n_err, 0);
    check("clr_err_total", err_total, 0);
    check("clr_n_loss", n_loss, 0);
    for (int k = 0; k < 54; k++) send(1'b0);
    check("clr_relock_54", locked, 0);
    send(1'b0);
    check("clr_relock_55", locked, 1);

`ifdef PRBS_ERR_INJECT_EN
    poly_sel = 2'd0; win_len = '0;
    do_reset();
    for (int k = 0; k < 39; k++) send(1'b0);
    for (int k = 1; k <= 100; k++) begin
      inj = (k % 20) == 0;
      send(1'b0);
    end
    inj = 1'b0;
    check("inj_bit_err", err_pulses, 5);
    check("inj_err_total", err_total, 5);
    check("inj_locked", locked, 1);
    check("inj_n_loss", n_loss, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
